// File: rtl/poly_voice_mixer.sv
// Polyphonic phase-accumulator synth core: N voices with selectable waveform,
// advanced once per sample tick and mixed serially into one DAC sample.
module poly_voice_mixer #(
    parameter int N_VOICES   = 4,
    parameter int PHASE_W    = 16,
    parameter int OUT_W      = 12,
    parameter int SAMPLE_DIV = 250
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ena,
    input  logic                        cfg_we,
    input  logic [$clog2(N_VOICES)-1:0] cfg_voice,
    input  logic [PHASE_W-1:0]          cfg_inc,
    input  logic [1:0]                  cfg_wave,
    output logic [OUT_W-1:0]            signal,
    output logic                        sample_valid
);

    localparam int IDX_W = $clog2(N_VOICES);
    localparam int CNT_W = $clog2(SAMPLE_DIV);
    localparam int ACC_W = OUT_W + IDX_W;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_VOICES - 1);

    typedef enum logic [1:0] {
        WAVE_OFF    = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_SAW    = 2'd2,
        WAVE_TRI    = 2'd3
    } wave_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        OUTPUT
    } state_t;

    logic [CNT_W-1:0]   count;
    logic               tick;

    logic [PHASE_W-1:0] phase        [N_VOICES];
    logic [PHASE_W-1:0] pending_inc  [N_VOICES];
    logic [1:0]         pending_wave [N_VOICES];
    logic [1:0]         active_wave  [N_VOICES];

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_next;
    logic [OUT_W:0]     phase_top;
    logic [OUT_W-1:0]   voice_value;

    // ------------------------------------------------------------------
    // Sample-rate divider
    // ------------------------------------------------------------------
    assign tick = ena && (count == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (ena) begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            count <= (count == CNT_LAST) ? '0 : count + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Per-voice config and phase update
    // ------------------------------------------------------------------
    // The phase advance uses the pending increment directly, so only the
    // waveform selection needs an active copy for the mixer to read.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: these per-voice arrays are a handful of flops, not RAM,
            // so clearing them in reset is cheap and keeps state defined.
            for (int v = 0; v < N_VOICES; v++) begin
                phase[v]        <= '0;
                pending_inc[v]  <= '0;
                pending_wave[v] <= '0;
                active_wave[v]  <= '0;
            end
        end else begin
            if (tick) begin
                for (int v = 0; v < N_VOICES; v++) begin
                    active_wave[v] <= pending_wave[v];
                    if (pending_wave[v] != WAVE_OFF)
                        phase[v] <= phase[v] + pending_inc[v];
                end
            end
            // A write in the tick cycle lands in pending only; the tick above
            // already latched the pre-edge pending values.
            if (cfg_we) begin
                pending_inc[cfg_voice]  <= cfg_inc;
                pending_wave[cfg_voice] <= cfg_wave;
            end
        end
    end

    // ------------------------------------------------------------------
    // Waveform of the voice currently selected by the mixer
    // ------------------------------------------------------------------
    // phase_top holds the MSB plus the OUT_W bits below it: saw takes the
    // upper OUT_W, triangle takes the lower OUT_W.
    assign phase_top = phase[idx][PHASE_W-1 -: OUT_W+1];

    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        voice_value = '0;
        case (wave_t'(active_wave[idx]))
            WAVE_SQUARE: voice_value = phase_top[OUT_W] ? '1 : '0;
            WAVE_SAW:    voice_value = phase_top[OUT_W:1];
            WAVE_TRI:    voice_value = phase_top[OUT_W] ? ~phase_top[OUT_W-1:0]
                                                        :  phase_top[OUT_W-1:0];
            default:     voice_value = '0;
        endcase
    end

    assign acc_next = acc + ACC_W'(voice_value);

    // ------------------------------------------------------------------
    // Mixer FSM: one voice per cycle, then publish the averaged sample
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            acc          <= '0;
            signal       <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        state <= ACCUM;
                        acc   <= '0;
                        idx   <= '0;
                    end
                end
                ACCUM: begin
                    acc <= acc_next;
                    idx <= idx + 1'b1;
                    if (idx == IDX_LAST) begin
                        // Registered so the pulse and sample appear together
                        // for exactly the OUTPUT cycle.
                        signal       <= acc_next[ACC_W-1 -: OUT_W];
                        sample_valid <= 1'b1;
                        state        <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_poly_voice_mixer.sv
// Scoreboard bench for poly_voice_mixer: stimulus queues expected samples and
// their arrival cycle; a monitor pops and compares on every sample_valid.
module tb_poly_voice_mixer;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        cfg_we;
    logic [1:0]  cfg_voice;
    logic [15:0] cfg_inc;
    logic [1:0]  cfg_wave;
    logic [11:0] signal;
    logic        sample_valid;

    typedef struct {
        logic [11:0] sig;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   c0;

    poly_voice_mixer #(
        .N_VOICES  (4),
        .PHASE_W   (16),
        .OUT_W     (12),
        .SAMPLE_DIV(250)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .cfg_we      (cfg_we),
        .cfg_voice   (cfg_voice),
        .cfg_inc     (cfg_inc),
        .cfg_wave    (cfg_wave),
        .signal      (signal),
        .sample_valid(sample_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every sample_valid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && sample_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_valid: got pulse at cycle %0d signal 0x%0h, expected none",
                         cyc, signal);
            end else begin
                mon_e = sb.pop_front();
                check("sample_signal", signal, mon_e.sig);
                check("sample_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic expect_sample(input logic [11:0] sig, input int at);
        exp_t e;
        e.sig = sig;
        e.cyc = at;
        sb.push_back(e);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        ena    = 1'b0;
        cfg_we = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_signal", signal, 0);
        check("reset_valid", sample_valid, 0);
        rst = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] v, input logic [15:0] inc, input logic [1:0] w);
        cfg_we    = 1'b1;
        cfg_voice = v;
        cfg_inc   = inc;
        cfg_wave  = w;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    // Tick k after enabling at c0 ends at edge c0+250k; valid follows 5 cycles
    // into the mix, sampled at cycle c0+250k+4.
    localparam logic [11:0] TRI_SEQ [5] = '{12'h200, 12'h3FF, 12'h1FF, 12'h000, 12'h200};
    localparam logic [11:0] SQR_SEQ [4] = '{12'hFFF, 12'h000, 12'hFFF, 12'h000};

    initial begin
        rst       = 1'b1;
        ena       = 1'b0;
        cfg_we    = 1'b0;
        cfg_voice = '0;
        cfg_inc   = '0;
        cfg_wave  = '0;

        // 1: all voices off, pulses every 250 cycles with zero output
        do_reset();
        c0  = cyc;
        ena = 1'b1;
        for (int i = 0; i < 3; i++) expect_sample(12'h000, c0 + 254 + 250 * i);
        wait_until(c0 + 254 + 500 + 3);
        check("t1_drained", sb.size(), 0);

        // 2: voice 0 saw, inc 0x1000 -> (k mod 16) * 0x40
        do_reset();
        cfg_write(2'd0, 16'h1000, 2'd2);
        c0  = cyc;
        ena = 1'b1;
        for (int k = 1; k <= 17; k++) expect_sample(12'((k % 16) * 'h40), c0 + 250 * k + 4);
        wait_until(c0 + 250 * 17 + 7);
        check("t2_drained", sb.size(), 0);

        // 3: all voices square, inc 0x8000 -> alternating full scale / zero
        do_reset();
        for (int v = 0; v < 4; v++) cfg_write(2'(v), 16'h8000, 2'd1);
        c0  = cyc;
        ena = 1'b1;
        for (int k = 1; k <= 4; k++) expect_sample(SQR_SEQ[k-1], c0 + 250 * k + 4);
        wait_until(c0 + 250 * 4 + 7);
        check("t3_drained", sb.size(), 0);

        // 4: voice 2 triangle, inc 0x4000
        do_reset();
        cfg_write(2'd2, 16'h4000, 2'd3);
        c0  = cyc;
        ena = 1'b1;
        for (int k = 1; k <= 5; k++) expect_sample(TRI_SEQ[k-1], c0 + 250 * k + 4);
        wait_until(c0 + 250 * 5 + 7);
        check("t4_drained", sb.size(), 0);

        // 5a: pause after 300 enabled cycles (count=50), hold 1000 cycles,
        // resume: tick after 199 more enabled cycles -> edge c0+1500
        do_reset();
        cfg_write(2'd0, 16'h1000, 2'd2);
        c0  = cyc;
        ena = 1'b1;
        expect_sample(12'h040, c0 + 254);
        wait_until(c0 + 300);
        ena = 1'b0;
        expect_sample(12'h080, c0 + 1504);
        wait_until(c0 + 400);
        check("hold_signal_a", signal, 12'h040);
        wait_until(c0 + 800);
        check("hold_signal_b", signal, 12'h040);
        wait_until(c0 + 1300);
        check("hold_signal_c", signal, 12'h040);
        ena = 1'b1;
        wait_until(c0 + 1507);
        check("t5a_drained", sb.size(), 0);

        // 5b: reset during ACCUM aborts the mix
        do_reset();
        cfg_write(2'd0, 16'h1000, 2'd2);
        c0  = cyc;
        ena = 1'b1;
        wait_until(c0 + 252);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_reset_signal", signal, 0);
        check("abort_reset_valid", sample_valid, 0);
        rst = 1'b0;
        wait_until(c0 + 300);
        check("abort_signal", signal, 0);
        check("t5b_drained", sb.size(), 0);

        // 6: write on the tick cycle applies one tick later
        do_reset();
        cfg_write(2'd0, 16'h1000, 2'd2);
        c0  = cyc;
        ena = 1'b1;
        expect_sample(12'h040, c0 + 254);
        expect_sample(12'h0C0, c0 + 504);
        expect_sample(12'h140, c0 + 754);
        wait_until(c0 + 249);
        cfg_write(2'd0, 16'h2000, 2'd2);
        wait_until(c0 + 757);
        check("t6_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/poly_voice_mixer.md
Name: poly_voice_mixer

Overview:
- Parametrised successor to the single-output synth core: N independent phase-accumulator voices, each with selectable waveform, mixed into one OUT_W-bit DAC sample.
- Sits between the control/button logic (per-voice config writes) and the DAC driver that consumes `signal`.
- Sample-rate divider, voice update and time-multiplexed mixing are all internal.

Parameters:
- N_VOICES, 4: voice count; must be a power of two and ≥ 2.
- PHASE_W, 16: phase accumulator width; must be ≥ OUT_W+2.
- OUT_W, 12: output sample width.
- SAMPLE_DIV, 250: clocks per sample (48 kHz at 12 MHz); must be > N_VOICES+2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  run enable for the sample divider.
- cfg_we  in  1  config write strobe.
- cfg_voice  in  $clog2(N_VOICES)  target voice.
- cfg_inc  in  PHASE_W  phase increment per sample.
- cfg_wave  in  2  waveform: 0 off, 1 square, 2 saw, 3 triangle.
- signal  out  OUT_W  mixed sample, held between updates.
- sample_valid  out  1  one-cycle pulse when `signal` updates.

Behaviour:
- Reset (synchronous, rst=1 at posedge): all outputs and internal state go to 0.
  - Cleared: divider count, all phases, pending and active inc/wave, accumulator, FSM (→ IDLE).
  - Outputs: signal=0, sample_valid=0.
  - A reset mid-mix aborts the mix; no sample_valid is produced.
- Divider:
  - When ena=1, it counts 0..SAMPLE_DIV-1 and wraps.
  - "tick" is the cycle in which ena=1 and count==SAMPLE_DIV-1.
  - When ena=0, the count holds and no tick occurs. An in-flight mix still completes.
- Config writes:
  - cfg_we=1 registers cfg_inc/cfg_wave into the pending slot of cfg_voice. Writes are accepted regardless of ena.
  - A later write before the next tick overwrites the earlier one.
- On the tick cycle, for every voice:
  - active inc/wave ← pending inc/wave, using values registered before this edge. A write in the tick cycle itself applies at the following tick.
  - phase ← (phase + pending_inc) mod 2^PHASE_W if pending_wave≠0; otherwise phase holds.
- FSM:
  - IDLE → ACCUM on tick; acc ← 0, idx ← 0.
  - ACCUM: one voice per cycle, acc += wave(idx), idx 0..N_VOICES-1. After idx=N_VOICES-1, go to OUTPUT.
  - OUTPUT: signal ← acc >> log2(N_VOICES); sample_valid=1 for this cycle only; go to IDLE.
  - Latency: sample_valid is asserted exactly N_VOICES+1 cycles after the tick cycle. Because SAMPLE_DIV > N_VOICES+2, a tick never arrives outside IDLE.
- Waveform of a voice with phase p (MSB = p[PHASE_W-1]):
  - off: 0.
  - square: MSB ? 2^OUT_W-1 : 0.
  - saw: p[PHASE_W-1 -: OUT_W].
  - triangle: t = p[PHASE_W-2 -: OUT_W]; value = MSB ? ~t : t.
- Width and overflow: acc is OUT_W+log2(N_VOICES) bits and cannot overflow. Phase wrap-around is modular with no flag.

Test Plan (N_VOICES=4, PHASE_W=16, OUT_W=12, SAMPLE_DIV=250 unless noted):
1. Reset, then ena=1 with all voices off:
   - sample_valid pulses every 250 cycles, 5 cycles after each tick.
   - signal stays 0x000; all outputs are 0 during reset.
2. Voice 0 saw, inc=0x1000:
   - After tick k, signal = ((k·0x1000 mod 0x10000)[15:4]) >> 2 = (k mod 16)·0x40.
   - k=15 gives 0x3C0; k=16 gives 0x000.
3. All four voices square, inc=0x8000:
   - Tick 1: phases 0x8000, signal=0xFFF.
   - Tick 2: phases 0x0000, signal=0x000; this alternation continues.
4. Voice 2 triangle, inc=0x4000 → signal sequence 0x200, 0x3FF, 0x1FF, 0x000, 0x200, …
5. Enable and reset interactions:
   - Deassert ena for 1000 cycles: no sample_valid, signal holds its last value, divider count holds.
   - Reassert ena: the next tick arrives after the remaining count.
   - Separately, pulse rst during ACCUM: signal=0 and no sample_valid for that mix.
6. Write coincident with tick:
   - cfg_we on the tick cycle is not applied; the phase advances by the old pending inc.
   - The new inc and wave take effect at the next tick, verified via the saw slope change.
